// File: rtl/cov_pkg.sv
// Shared definitions for the coverage-sum accumulator and its consumers:
// default output width, partial-popcount sizing and a popcount helper.
package cov_pkg;

    // Width of the coverage sum, also used by the monitor's cov input.
    localparam int COV_W_DEFAULT  = 30;

    // Default chunk size and the resulting partial-count width.
    localparam int CHUNK_DEFAULT  = 16;
    localparam int PART_W_DEFAULT = $clog2(CHUNK_DEFAULT) + 1;

    // Widest chunk the popcount helper can handle.
    localparam int MAX_CHUNK      = 64;

    // Partial-count width for an arbitrary chunk size.
    function automatic int cov_part_w(input int chunk);
        return $clog2(chunk) + 1;
    endfunction

    // Number of set bits in a MAX_CHUNK-bit vector. Narrower callers
    // zero-extend their operand.
    function automatic logic [7:0] cov_popcount(input logic [MAX_CHUNK-1:0] v);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_CHUNK; i++) begin
            cnt = cnt + {7'b0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cov_sum_accumulator_if.sv
// Hit-vector input and coverage-count output bundle of the accumulator.
interface cov_sum_accumulator_if
    import cov_pkg::*;
#(
    parameter int NUM_POINTS = 64,
    parameter int COV_W      = COV_W_DEFAULT
);
    logic                  clear;
    logic                  hit_valid;
    logic [NUM_POINTS-1:0] hit_vec;
    logic [COV_W-1:0]      cov_sum;
    logic                  cov_new;
    logic                  cov_full;

    // Driver side: harness / instrumented DUT.
    modport master (
        output clear, hit_valid, hit_vec,
        input  cov_sum, cov_new, cov_full
    );

    // Accumulator side.
    modport slave (
        input  clear, hit_valid, hit_vec,
        output cov_sum, cov_new, cov_full
    );
endinterface

// File: rtl/cov_popcount_chunk.sv
// Registered popcount of one CHUNK-bit slice of the first-hit vector,
// carrying the pipeline valid alongside the partial count.
module cov_popcount_chunk
    import cov_pkg::*;
#(
    parameter int CHUNK  = CHUNK_DEFAULT,
    parameter int PART_W = $clog2(CHUNK) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_vld,
    input  logic [CHUNK-1:0]  in_bits,
    output logic [PART_W-1:0] part,
    output logic              vld
);

    generate
        if (CHUNK > MAX_CHUNK || CHUNK < 1) begin : g_bad_chunk
            $error("cov_popcount_chunk: CHUNK out of range");
        end
    endgenerate

    logic [MAX_CHUNK-1:0] bits_ext;
    logic [PART_W-1:0]    part_d, part_q;
    logic                 vld_d, vld_q;

    // Zero-extend the slice and compute the next partial count.
    always_comb begin
        bits_ext             = '0;
        bits_ext[CHUNK-1:0]  = in_bits;
        part_d               = PART_W'(cov_popcount(bits_ext));
        vld_d                = in_vld;
        if (clear) begin
            part_d = '0;
            vld_d  = 1'b0;
        end
    end

    // Stage-2 register for this chunk.
    always_ff @(posedge clock) begin
        if (!reset) begin
            part_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            part_q <= part_d;
            vld_q  <= vld_d;
        end
    end

    assign part = part_q;
    assign vld  = vld_q;

endmodule

// File: rtl/cov_sum_accumulator.sv
// Three-stage coverage accumulator: sticky seen bitmap and first-hit
// extraction, chunked popcount, then saturating accumulation.
module cov_sum_accumulator
    import cov_pkg::*;
#(
    parameter int NUM_POINTS = 64,
    parameter int CHUNK      = CHUNK_DEFAULT,
    parameter int COV_W      = COV_W_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    cov_sum_accumulator_if.slave  bus
);

    localparam int NCHUNK = NUM_POINTS / CHUNK;
    localparam int PART_W = cov_part_w(CHUNK);
    localparam int INC_W  = $clog2(NUM_POINTS + 1);

    generate
        if ((NUM_POINTS % CHUNK) != 0) begin : g_bad_chunking
            $error("cov_sum_accumulator: NUM_POINTS must be a multiple of CHUNK");
        end
        if (longint'(NUM_POINTS) >= (64'd1 << COV_W)) begin : g_bad_width
            $error("cov_sum_accumulator: NUM_POINTS must be below 2**COV_W");
        end
    endgenerate

    // Stage 1 state
    logic [NUM_POINTS-1:0] seen_d, seen_q;
    logic [NUM_POINTS-1:0] s1_new_d, s1_new_q;
    logic                  s1_vld_d, s1_vld_q;
    logic                  cov_full_d, cov_full_q;

    // Stage 2 outputs
    logic [PART_W-1:0]     s2_part [NCHUNK];
    logic [NCHUNK-1:0]     s2_vld_vec;
    logic                  s2_vld;

    // Stage 3 state
    logic [INC_W-1:0]      inc;
    logic [COV_W:0]        sum_wide;
    logic [COV_W-1:0]      cov_sum_d, cov_sum_q;
    logic                  cov_new_d, cov_new_q;

    // Stage 1: mark newly seen points; a clear discards the incoming vector.
    always_comb begin
        seen_d   = seen_q;
        s1_new_d = '0;
        s1_vld_d = 1'b0;
        if (bus.clear) begin
            seen_d = '0;
        end else if (bus.hit_valid) begin
            s1_new_d = bus.hit_vec & ~seen_q;
            seen_d   = seen_q | bus.hit_vec;
            s1_vld_d = 1'b1;
        end
        cov_full_d = &seen_d;
    end

    // Stage 1 registers; cov_full tracks seen on the same edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            seen_q     <= '0;
            s1_new_q   <= '0;
            s1_vld_q   <= 1'b0;
            cov_full_q <= 1'b0;
        end else begin
            seen_q     <= seen_d;
            s1_new_q   <= s1_new_d;
            s1_vld_q   <= s1_vld_d;
            cov_full_q <= cov_full_d;
        end
    end

    // Stage 2: one registered popcount per chunk.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            cov_popcount_chunk #(
                .CHUNK  (CHUNK),
                .PART_W (PART_W)
            ) u_chunk (
                .clock   (clock),
                .reset   (reset),
                .clear   (bus.clear),
                .in_vld  (s1_vld_q),
                .in_bits (s1_new_q[gi*CHUNK +: CHUNK]),
                .part    (s2_part[gi]),
                .vld     (s2_vld_vec[gi])
            );
        end
    endgenerate

    // All chunk valids carry the same stage-1 valid.
    assign s2_vld = &s2_vld_vec;

    // Stage 3: add the partials and accumulate with saturation.
    always_comb begin
        inc = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            inc = inc + INC_W'(s2_part[k]);
        end
        sum_wide  = {1'b0, cov_sum_q} + (COV_W+1)'(inc);
        cov_sum_d = cov_sum_q;
        cov_new_d = 1'b0;
        if (bus.clear) begin
            cov_sum_d = '0;
        end else if (s2_vld && (inc != '0)) begin
            cov_sum_d = sum_wide[COV_W] ? {COV_W{1'b1}} : sum_wide[COV_W-1:0];
            cov_new_d = 1'b1;
        end
    end

    // Stage 3 registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cov_sum_q <= '0;
            cov_new_q <= 1'b0;
        end else begin
            cov_sum_q <= cov_sum_d;
            cov_new_q <= cov_new_d;
        end
    end

    assign bus.cov_sum  = cov_sum_q;
    assign bus.cov_new  = cov_new_q;
    assign bus.cov_full = cov_full_q;

endmodule

// File: tb/tb_cov_sum_accumulator.sv
// Self-checking bench for cov_sum_accumulator: directed scenarios plus
// randomized hit traffic against a set-based reference model.
module tb_cov_sum_accumulator;

    localparam int NUM_POINTS = 64;
    localparam int CHUNK      = 16;
    localparam int COV_W      = 30;
    localparam longint SUM_MAX = (64'd1 << COV_W) - 1;

    logic clock;
    logic reset;

    cov_sum_accumulator_if #(.NUM_POINTS(NUM_POINTS), .COV_W(COV_W)) bus ();

    cov_sum_accumulator #(
        .NUM_POINTS (NUM_POINTS),
        .CHUNK      (CHUNK),
        .COV_W      (COV_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Reference model: set of seen points, running count, and the counts
    // of first hits still travelling toward the output.
    logic [NUM_POINTS-1:0] m_seen;
    longint                m_sum;
    logic                  m_new;
    logic                  m_full;
    int                    m_pending[$];

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (txn %0d)", tag, got, exp, txn);
        end
    endtask

    task automatic model_reset();
        m_seen    = '0;
        m_sum     = 0;
        m_new     = 1'b0;
        m_full    = 1'b0;
        m_pending = '{0, 0};
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge.
    task automatic drive(input logic rst_n, input logic clr, input logic vld,
                         input logic [NUM_POINTS-1:0] vec);
        int n;
        int f;
        reset         = rst_n;
        bus.clear     = clr;
        bus.hit_valid = vld;
        bus.hit_vec   = vec;
        @(posedge clock);
        if (!rst_n || clr) begin
            model_reset();
        end else begin
            n = vld ? $countones(vec & ~m_seen) : 0;
            if (vld) m_seen = m_seen | vec;
            m_full = (m_seen == {NUM_POINTS{1'b1}});
            f = m_pending.pop_front();
            if (f != 0) begin
                m_sum = (m_sum + f > SUM_MAX) ? SUM_MAX : m_sum + f;
                m_new = 1'b1;
            end else begin
                m_new = 1'b0;
            end
            m_pending.push_back(n);
        end
        #1;
        txn++;
        $display("txn %0d rst_n=%0b clr=%0b vld=%0b vec=%h -> sum=%0d new=%0b full=%0b",
                 txn, rst_n, clr, vld, vec, bus.cov_sum, bus.cov_new, bus.cov_full);
        check_val("cov_sum",  longint'(bus.cov_sum),  m_sum);
        check_val("cov_new",  longint'(bus.cov_new),  longint'(m_new));
        check_val("cov_full", longint'(bus.cov_full), longint'(m_full));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b1, 1'b0, 1'b0, '0);
    endtask

    localparam logic [NUM_POINTS-1:0] ONES = {NUM_POINTS{1'b1}};

    initial begin
        logic [NUM_POINTS-1:0] rv;
        model_reset();
        reset         = 1'b0;
        bus.clear     = 1'b0;
        bus.hit_valid = 1'b0;
        bus.hit_vec   = '0;

        // Reset holds everything low even with full hit traffic.
        drive(1'b0, 1'b0, 1'b1, ONES);
        drive(1'b0, 1'b0, 1'b1, ONES);
        check_val("rst_sum", longint'(bus.cov_sum), 0);
        check_val("rst_full", longint'(bus.cov_full), 0);
        idle(4);
        check_val("post_rst_sum", longint'(bus.cov_sum), 0);

        // Single hit, then a repeat of the same points.
        drive(1'b1, 1'b0, 1'b1, 64'h000F);
        idle(1);
        check_val("single_early", longint'(bus.cov_sum), 0);
        idle(1);
        check_val("single_sum", longint'(bus.cov_sum), 4);
        check_val("single_new", longint'(bus.cov_new), 1);
        idle(1);
        check_val("single_new_drop", longint'(bus.cov_new), 0);
        drive(1'b1, 1'b0, 1'b1, 64'h000F);
        idle(4);
        check_val("repeat_sum", longint'(bus.cov_sum), 4);

        // Overlapping back-to-back vectors.
        drive(1'b1, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b1, 64'h3);
        drive(1'b1, 1'b0, 1'b1, 64'h6);
        idle(1);
        check_val("b2b_first", longint'(bus.cov_sum), 2);
        idle(1);
        check_val("b2b_second", longint'(bus.cov_sum), 3);

        // Invalid vectors are ignored; a later valid one still counts.
        drive(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 64'hFFFF);
        drive(1'b1, 1'b0, 1'b1, 64'h1);
        idle(3);
        check_val("invalid_then_valid", longint'(bus.cov_sum), 1);

        // Clear while results are in flight.
        drive(1'b1, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b1, 64'hFF);
        drive(1'b1, 1'b1, 1'b0, '0);
        idle(4);
        check_val("clear_drop", longint'(bus.cov_sum), 0);
        drive(1'b1, 1'b0, 1'b1, 64'hFF);
        idle(2);
        check_val("clear_refill", longint'(bus.cov_sum), 8);

        // Hit arriving with clear is discarded.
        drive(1'b1, 1'b1, 1'b1, ONES);
        idle(3);
        check_val("clear_hit_drop", longint'(bus.cov_sum), 0);
        check_val("clear_hit_full", longint'(bus.cov_full), 0);

        // Full coverage.
        drive(1'b1, 1'b0, 1'b1, ONES);
        check_val("full_flag", longint'(bus.cov_full), 1);
        idle(2);
        check_val("full_sum", longint'(bus.cov_sum), 64);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, ONES);
        idle(3);
        check_val("full_hold", longint'(bus.cov_sum), 64);

        // Randomized sparse traffic with occasional clears and resets.
        drive(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 400; i++) begin
            rv = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rv = rv & {$urandom, $urandom} & {$urandom, $urandom};
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 1) == 1),
                  rv);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
